skip_table_cfg_ctrl: RTL



---
 rtl/skip_table_cfg_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/skip_table_cfg_ctrl.sv
// Skip table configuration sequencer: expands host commands into
// ordered single-word table writes and tracks a shadow valid bitmap.
module skip_table_cfg_ctrl #(
  parameter int SKIP_TABLE_SIZE = 16,
  parameter logic [29-$clog2(SKIP_TABLE_SIZE):0] TABLE_BLOCK_IDX = '1
) (
  input  logic                               ClockIn,
  input  logic                               ResetIn,
  input  logic                               CmdValidIn,
  output logic                               CmdReadyOut,
  input  logic [1:0]                         CmdOpIn,
  input  logic [$clog2(SKIP_TABLE_SIZE)-1:0] CmdIdxIn,
  input  logic [31:0]                        CmdPCIn,
  input  logic [31:0]                        CmdEntryIn,
  output logic                               WriteEnOut,
  output logic [31:0]                        WriteAddressOut,
  output logic [31:0]                        WriteDataOut,
  output logic                               BusyOut,
  output logic                               DoneOut,
  output logic [$clog2(SKIP_TABLE_SIZE)-1:0] DoneIdxOut,
  output logic                               ErrorOut,
  output logic [SKIP_TABLE_SIZE-1:0]         ValidMaskOut
);

  localparam int IW = $clog2(SKIP_TABLE_SIZE);
  localparam logic [IW-1:0] LAST = IW'(SKIP_TABLE_SIZE - 1);

  localparam logic [1:0] OP_PROGRAM = 2'd0;
  localparam logic [1:0] OP_ALLOC   = 2'd1;
  localparam logic [1:0] OP_INVAL   = 2'd2;
  localparam logic [1:0] OP_FLUSH   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR_HIDE,
    WR_PC,
    WR_ENTRY,
    WR_CLR,
    FLUSH,
    DONE
  } stateT;

  stateT stateQ, stateD;

  logic [IW-1:0]              idxQ, idxD;
  logic [31:0]                pcQ, pcD;
  logic [31:0]                entryQ, entryD;
  logic [IW-1:0]              cntQ, cntD;
  logic [SKIP_TABLE_SIZE-1:0] maskD;

  logic          readyD, wenD, busyD, doneD, errD;
  logic [31:0]   addrD, dataD;
  logic [IW-1:0] doneIdxD;

  logic [IW-1:0] freeIdx;
  logic [IW-1:0] selIdx;
  logic          allFull;

  function automatic logic [31:0] wrAddr(
    input logic [IW-1:0] idx,
    input logic          off
  );
    return {TABLE_BLOCK_IDX, 1'b0, idx, off};
  endfunction

  // Lowest free slot; the highest index is visited first so low wins.
  always_comb begin
    freeIdx = '0;
    for (int i = SKIP_TABLE_SIZE - 1; i >= 0; i--) begin
      if (!ValidMaskOut[i]) freeIdx = IW'(i);
    end
  end

  assign allFull = &ValidMaskOut;
  assign selIdx  = (CmdOpIn == OP_ALLOC) ? freeIdx : CmdIdxIn;

  always_comb begin
    stateD   = stateQ;
    idxD     = idxQ;
    pcD      = pcQ;
    entryD   = entryQ;
    cntD     = cntQ;
    maskD    = ValidMaskOut;
    readyD   = 1'b0;
    wenD     = 1'b0;
    addrD    = '0;
    dataD    = '0;
    busyD    = 1'b1;
    doneD    = 1'b0;
    doneIdxD = '0;
    errD     = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (CmdValidIn && CmdReadyOut) begin
          idxD   = selIdx;
          pcD    = CmdPCIn;
          entryD = CmdEntryIn;
          unique case (CmdOpIn)
            OP_PROGRAM, OP_ALLOC: begin
              if (CmdOpIn == OP_ALLOC && allFull) begin
                stateD = DONE;
                doneD  = 1'b1;
                errD   = 1'b1;
              end else begin
                // Hide the entry before its PC changes under the CAM.
                stateD        = WR_HIDE;
                wenD          = 1'b1;
                addrD         = wrAddr(selIdx, 1'b1);
                dataD         = {1'b0, CmdEntryIn[30:0]};
                maskD[selIdx] = 1'b0;
              end
            end
            OP_INVAL: begin
              stateD          = WR_CLR;
              wenD            = 1'b1;
              addrD           = wrAddr(CmdIdxIn, 1'b1);
              maskD[CmdIdxIn] = 1'b0;
            end
            OP_FLUSH: begin
              stateD = FLUSH;
              cntD   = '0;
              wenD   = 1'b1;
              addrD  = wrAddr('0, 1'b1);
            end
          endcase
        end else begin
          readyD = 1'b1;
          busyD  = 1'b0;
        end
      end
      WR_HIDE: begin
        stateD = WR_PC;
        wenD   = 1'b1;
        addrD  = wrAddr(idxQ, 1'b0);
        dataD  = pcQ;
      end
      WR_PC: begin
        stateD      = WR_ENTRY;
        wenD        = 1'b1;
        addrD       = wrAddr(idxQ, 1'b1);
        dataD       = entryQ;
        maskD[idxQ] = entryQ[31];
      end
      WR_ENTRY, WR_CLR: begin
        stateD   = DONE;
        doneD    = 1'b1;
        doneIdxD = idxQ;
      end
      FLUSH: begin
        if (cntQ == LAST) begin
          stateD   = DONE;
          doneD    = 1'b1;
          doneIdxD = LAST;
        end else begin
          cntD  = cntQ + 1'b1;
          wenD  = 1'b1;
          addrD = wrAddr(cntQ + 1'b1, 1'b1);
          if (cntQ + 1'b1 == LAST) maskD = '0;
        end
      end
      default: begin
        stateD = IDLE;
        readyD = 1'b1;
        busyD  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      stateQ          <= IDLE;
      idxQ            <= '0;
      pcQ             <= '0;
      entryQ          <= '0;
      cntQ            <= '0;
      ValidMaskOut    <= '0;
      CmdReadyOut     <= 1'b1;
      WriteEnOut      <= 1'b0;
      WriteAddressOut <= '0;
      WriteDataOut    <= '0;
      BusyOut         <= 1'b0;
      DoneOut         <= 1'b0;
      DoneIdxOut      <= '0;
      ErrorOut        <= 1'b0;
    end else begin
      stateQ          <= stateD;
      idxQ            <= idxD;
      pcQ             <= pcD;
      entryQ          <= entryD;
      cntQ            <= cntD;
      ValidMaskOut    <= maskD;
      CmdReadyOut     <= readyD;
      WriteEnOut      <= wenD;
      WriteAddressOut <= addrD;
      WriteDataOut    <= dataD;
      BusyOut         <= busyD;
      DoneOut         <= doneD;
      DoneIdxOut      <= doneIdxD;
      ErrorOut        <= errD;
    end
  end

endmodule
